route_compute_unit: RTL

- Packet-level routing computer for the quadtree router, generalised over tree level and fanout.
- Sits between an input port's buffer head and the switch allocator.
- Accepts one head flit per packet and computes a one-hot/multicast output vector from direction, route_info and route_addr.
- Registers the vector and holds it until the packet's tail has departed.
- Drops unroutable heads and counts them.

---
 rtl/route_compute_unit_if.sv | 38 +++
 rtl/route_compute_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/route_compute_unit_if.sv
// Head-flit / route handshake bundle between an input buffer, the route
// computer and the switch allocator.
`ifndef DIR_WIDTH
`define DIR_WIDTH 3
`endif
`ifndef ROUTER_INFO_WIDTH
`define ROUTER_INFO_WIDTH 3
`endif

interface route_compute_unit_if #(
    parameter int ADDR_W    = 16,
    parameter int NUM_CHILD = 4,
    parameter int CNT_W     = 8
);
    logic [`DIR_WIDTH-1:0]         direction;
    logic                          head_valid;
    logic                          head_ready;
    logic [`ROUTER_INFO_WIDTH-1:0] route_info;
    logic [ADDR_W-1:0]             route_addr;
    logic                          pkt_done;
    logic                          route_valid;
    logic [NUM_CHILD:0]            route_port;
    logic                          err_unroutable;
    logic                          err_orphan;
    logic [CNT_W-1:0]              drop_cnt;

    modport master (
        output direction, head_valid, route_info, route_addr, pkt_done,
        input  head_ready, route_valid, route_port, err_unroutable,
               err_orphan, drop_cnt
    );

    modport slave (
        input  direction, head_valid, route_info, route_addr, pkt_done,
        output head_ready, route_valid, route_port, err_unroutable,
               err_orphan, drop_cnt
    );
endinterface

// File: rtl/route_compute_unit.sv
// Per-input-port route computer for the quadtree router: turns a head flit into
// a child/parent output vector and holds it until the packet tail has left.
`ifndef DIR_WIDTH
`define DIR_WIDTH 3
`endif
`ifndef ROUTER_INFO_WIDTH
`define ROUTER_INFO_WIDTH 3
`endif
`ifndef DIR_LOCAL
`define DIR_LOCAL 3'd0
`endif
`ifndef RI_CONFIG
`define RI_CONFIG        3'd0
`define RI_READ          3'd1
`define RI_CALC          3'd2
`define RI_BROADCAST     3'd3
`define RI_FIN_BROADCAST 3'd4
`define RI_FIN_COMP      3'd5
`endif

module route_compute_unit #(
    parameter int LEVEL_IDX = 0,
    parameter int NUM_CHILD = 4,
    parameter int ADDR_W    = 16,
    parameter int ADDR_MSB  = 15,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    route_compute_unit_if.slave     rif
);
    localparam int CHILD_BITS = $clog2(NUM_CHILD);
    localparam int SEL_HI     = ADDR_MSB - LEVEL_IDX * CHILD_BITS;
    localparam int SEL_LO     = SEL_HI - CHILD_BITS + 1;
    // Out-of-range fields are reported below; the clamp only keeps elaboration legal.
    localparam int SEL_HI_OK  = (SEL_LO < 0 || SEL_HI >= ADDR_W) ? (CHILD_BITS - 1) : SEL_HI;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    localparam logic [NUM_CHILD:0] ALL_CHILD = {1'b0, {NUM_CHILD{1'b1}}};
    localparam logic [NUM_CHILD:0] PARENT    = {1'b1, {NUM_CHILD{1'b0}}};

    if (NUM_CHILD < 2 || (1 << CHILD_BITS) != NUM_CHILD) begin : g_bad_child
        $error("route_compute_unit: NUM_CHILD=%0d is not a power of two >= 2", NUM_CHILD);
    end
    if (SEL_LO < 0 || SEL_HI >= ADDR_W) begin : g_bad_field
        $error("route_compute_unit: address field [%0d:%0d] outside route_addr", SEL_HI, SEL_LO);
    end

    function automatic logic [NUM_CHILD:0] route_fn(
        input logic [`DIR_WIDTH-1:0]         dir,
        input logic [`ROUTER_INFO_WIDTH-1:0] info,
        input logic [CHILD_BITS-1:0]         sel
    );
        logic [NUM_CHILD:0] r;
        r = '0;
        if (dir == `DIR_LOCAL) begin
            case (info)
                `RI_CONFIG, `RI_READ:                 r[sel] = 1'b1;
                `RI_CALC, `RI_FIN_BROADCAST, `RI_FIN_COMP: r = ALL_CHILD;
                `RI_BROADCAST: begin
                    if (LEVEL_IDX > 0) begin
                        r = ALL_CHILD;
                    end else begin
                        r = '0;
                    end
                end
                default:                              r = '0;
            endcase
        end else begin
            // Upward traffic: only the root turns a broadcast back down.
            case (info)
                `RI_BROADCAST: begin
                    if (LEVEL_IDX == 0) begin
                        r = ALL_CHILD;
                    end else begin
                        r = PARENT;
                    end
                end
                `RI_FIN_BROADCAST, `RI_FIN_COMP, `RI_READ: r = PARENT;
                default:                              r = '0;
            endcase
        end
        return r;
    endfunction

    logic [0:0]          state_q, state_d;
    logic                route_valid_q, route_valid_d;
    logic [NUM_CHILD:0]  route_port_q, route_port_d;
    logic                err_unroutable_q, err_unroutable_d;
    logic                err_orphan_q, err_orphan_d;
    logic [CNT_W-1:0]    drop_cnt_q, drop_cnt_d;

    logic [CHILD_BITS-1:0] sel_s;
    logic [NUM_CHILD:0]    route_s;
    logic                  unused_addr_s;

    assign sel_s         = rif.route_addr[SEL_HI_OK -: CHILD_BITS];
    assign unused_addr_s = ^rif.route_addr;
    assign route_s       = route_fn(rif.direction, rif.route_info, sel_s);

    // Next-state, held route and error/drop bookkeeping.
    always_comb begin
        state_d          = state_q;
        route_valid_d    = route_valid_q;
        route_port_d     = route_port_q;
        err_unroutable_d = 1'b0;
        err_orphan_d     = 1'b0;
        drop_cnt_d       = drop_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rif.pkt_done) begin
                    err_orphan_d = 1'b1;
                end else begin
                    err_orphan_d = 1'b0;
                end
                if (rif.head_valid) begin
                    if (route_s != '0) begin
                        route_port_d  = route_s;
                        route_valid_d = 1'b1;
                        state_d       = ST_ACTIVE;
                    end else begin
                        err_unroutable_d = 1'b1;
                        if (drop_cnt_q != {CNT_W{1'b1}}) begin
                            drop_cnt_d = drop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                        end else begin
                            drop_cnt_d = drop_cnt_q;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                // A head arriving alongside pkt_done waits: head_ready is low here.
                if (rif.pkt_done) begin
                    route_valid_d = 1'b0;
                    route_port_d  = '0;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                route_valid_d = 1'b0;
                route_port_d  = '0;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any held route at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            route_valid_q    <= 1'b0;
            route_port_q     <= '0;
            err_unroutable_q <= 1'b0;
            err_orphan_q     <= 1'b0;
            drop_cnt_q       <= '0;
        end else begin
            state_q          <= state_d;
            route_valid_q    <= route_valid_d;
            route_port_q     <= route_port_d;
            err_unroutable_q <= err_unroutable_d;
            err_orphan_q     <= err_orphan_d;
            drop_cnt_q       <= drop_cnt_d;
        end
    end

    assign rif.head_ready     = (state_q == ST_IDLE);
    assign rif.route_valid    = route_valid_q;
    assign rif.route_port     = route_port_q;
    assign rif.err_unroutable = err_unroutable_q;
    assign rif.err_orphan     = err_orphan_q;
    assign rif.drop_cnt       = drop_cnt_q;
endmodule
